// File: rtl/cva5_types_pkg.sv
// Shared cva5 types: load-type fn3 encodings and the per-load attribute entry
// held between issue and data return.
package cva5_types_pkg;

    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;

    // Attributes captured at issue; the instruction id travels alongside
    // since its width is a per-instance parameter.
    typedef struct packed {
        logic [2:0] fn3;
        logic [1:0] offset;
        logic       discard;
    } load_attr_t;

    localparam int unsigned LOAD_ATTR_W = $bits(load_attr_t);

endpackage

// File: rtl/cva5_fifo.sv
// Generic circular FIFO with occupancy count.
// Ports: clk, rst_n (async active-low), push/data_in, pop/data_out (head,
// valid while !empty), count (entries held), full, empty.
// Push while full and pop while empty are ignored.
module cva5_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       pop,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= CNT_W'(count + 1'b1);
                2'b01:   count <= CNT_W'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/load_return_unit.sv
// Load return unit: remembers id/type/offset of each in-flight load, pairs
// in-order memory responses with them, aligns and extends the data, and holds
// the result in a single output register until writeback acknowledges it.
// Ports: clk, rst_n; flush; req_valid/req_ready/req_id/req_fn3/req_offset
// (issue side); rsp_valid/rsp_data/rsp_ready (memory side);
// wb_valid/wb_ack/wb_id/wb_data/wb_discard (writeback side);
// outstanding (loads not yet returned); protocol_err (sticky).
module load_return_unit
    import cva5_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ID_W-1:0]            req_id,
    input  logic [2:0]                 req_fn3,
    input  logic [1:0]                 req_offset,
    input  logic                       rsp_valid,
    input  logic [31:0]                rsp_data,
    output logic                       rsp_ready,
    output logic                       wb_valid,
    input  logic                       wb_ack,
    output logic [ID_W-1:0]            wb_id,
    output logic [31:0]                wb_data,
    output logic                       wb_discard,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       protocol_err
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = ID_W + LOAD_ATTR_W;

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ID_W-1:0]    head_id;
    load_attr_t         push_attr;
    load_attr_t         head_attr;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               rsp_fire;

    // Number of entries at the head of the queue that predate a flush.
    logic [CNT_W-1:0]   discard_cnt;
    logic [CNT_W-1:0]   discard_cnt_next;
    logic               head_discard;

    logic [31:0]        shifted;
    logic [31:0]        aligned;

    assign req_ready = !fifo_full;
    assign rsp_ready = !wb_valid || wb_ack;
    assign push      = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign pop       = rsp_fire && !fifo_empty;

    assign push_attr  = '{fn3: req_fn3, offset: req_offset, discard: 1'b0};
    assign push_entry = {req_id, push_attr};
    assign {head_id, head_attr} = head_entry;

    cva5_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) attr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .data_in  (push_entry),
        .pop      (pop),
        .data_out (head_entry),
        .count    (outstanding),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Flush marks every entry already queued (and not popped this cycle);
    // since the queue is in order, a count of leading flushed entries is
    // equivalent to a per-entry discard flag. Same-cycle pushes stay clean.
    always_comb begin
        discard_cnt_next = discard_cnt;
        if (pop && (discard_cnt != '0)) begin
            discard_cnt_next = CNT_W'(discard_cnt - 1'b1);
        end
        if (flush) begin
            discard_cnt_next = CNT_W'(outstanding - CNT_W'(pop));
        end
    end

    assign head_discard = head_attr.discard || (discard_cnt != '0) || flush;

    // Byte-lane alignment and sign/zero extension of the response word.
    always_comb begin
        shifted = rsp_data >> {head_attr.offset, 3'b000};
        aligned = shifted;
        case (head_attr.fn3)
            FN3_LB:  aligned = {{24{shifted[7]}}, shifted[7:0]};
            FN3_LH:  aligned = {{16{shifted[15]}}, shifted[15:0]};
            FN3_LBU: aligned = {24'h0, shifted[7:0]};
            FN3_LHU: aligned = {16'h0, shifted[15:0]};
            default: aligned = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_cnt_next;
        end
    end

    // Output register: reloads on pop, drains on ack, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_id      <= '0;
            wb_data    <= '0;
            wb_discard <= 1'b0;
        end else if (pop) begin
            wb_valid   <= 1'b1;
            wb_id      <= head_id;
            wb_data    <= aligned;
            wb_discard <= head_discard;
        end else if (wb_ack && wb_valid) begin
            wb_valid   <= 1'b0;
            wb_discard <= 1'b0;
        end else if (flush && wb_valid) begin
            wb_discard <= 1'b1;
        end
    end

    // A response accepted with nothing outstanding is a memory-side bug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err <= 1'b0;
        end else if (rsp_fire && fifo_empty) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_return_unit.sv
module tb_load_return_unit;
    import cva5_types_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [ID_W-1:0]  req_id;
    logic [2:0]       req_fn3;
    logic [1:0]       req_offset;
    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic             rsp_ready;
    logic             wb_valid;
    logic             wb_ack;
    logic [ID_W-1:0]  wb_id;
    logic [31:0]      wb_data;
    logic             wb_discard;
    logic [CNT_W-1:0] outstanding;
    logic             protocol_err;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    load_return_unit #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_id       (req_id),
        .req_fn3      (req_fn3),
        .req_offset   (req_offset),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .wb_valid     (wb_valid),
        .wb_ack       (wb_ack),
        .wb_id        (wb_id),
        .wb_data      (wb_data),
        .wb_discard   (wb_discard),
        .outstanding  (outstanding),
        .protocol_err (protocol_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]      fn3;
        logic [1:0]      off;
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{FN3_LB,  2'd3, 3'd1, 32'h8011_2233, 32'hFFFF_FF80};
        vecs[1] = '{FN3_LHU, 2'd2, 3'd2, 32'h9ABC_1234, 32'h0000_9ABC};
        vecs[2] = '{FN3_LH,  2'd2, 3'd3, 32'h9ABC_1234, 32'hFFFF_9ABC};
        vecs[3] = '{FN3_LW,  2'd0, 3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{FN3_LBU, 2'd1, 3'd5, 32'h0000_A500, 32'h0000_00A5};
        vecs[5] = '{FN3_LB,  2'd0, 3'd6, 32'h0000_007F, 32'h0000_007F};
        vecs[6] = '{FN3_LH,  2'd0, 3'd7, 32'h0000_8001, 32'hFFFF_8001};
        vecs[7] = '{FN3_LBU, 2'd2, 3'd0, 32'h00FF_0000, 32'h0000_00FF};

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_id = '0;
        req_fn3 = FN3_LW; req_offset = 2'd0; rsp_valid = 1'b0;
        rsp_data = '0; wb_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_ready", 32'(rsp_ready), 32'd1);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset outstanding", 32'(outstanding), 32'd0);
        chk("reset protocol_err", 32'(protocol_err), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset wb_id", 32'(wb_id), 32'd0);

        // Alignment vectors: issue, respond one cycle later, check, ack.
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_id = vecs[i].id;
            req_fn3 = vecs[i].fn3; req_offset = vecs[i].off;
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("vec%0d outstanding", i), 32'(outstanding), 32'd1);
            rsp_valid = 1'b1; rsp_data = vecs[i].data;
            @(negedge clk);
            rsp_valid = 1'b0;
            chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'd1);
            chk($sformatf("vec%0d wb_id", i), 32'(wb_id), 32'(vecs[i].id));
            chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].exp);
            chk($sformatf("vec%0d wb_discard", i), 32'(wb_discard), 32'd0);
            wb_ack = 1'b1;
            @(negedge clk);
            wb_ack = 1'b0;
            chk($sformatf("vec%0d drained", i), 32'(wb_valid), 32'd0);
        end

        // Fill to DEPTH, then a blocked push alongside the first pop.
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_id = ID_W'(i); req_fn3 = FN3_LW; req_offset = 2'd0;
            @(negedge clk);
        end
        chk("full outstanding", 32'(outstanding), 32'd4);
        chk("full req_ready", 32'(req_ready), 32'd0);
        req_id = 3'd7;
        rsp_valid = 1'b1; rsp_data = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("after pop req_ready", 32'(req_ready), 32'd1);
        chk("after pop outstanding", 32'(outstanding), 32'd3);
        chk("first wb_id", 32'(wb_id), 32'd0);
        chk("first wb_data", wb_data, 32'h100);
        rsp_data = 32'h101; wb_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d rsp_ready", k), 32'(rsp_ready), 32'd0);
            chk($sformatf("stall%0d wb_id", k), 32'(wb_id), 32'd0);
            chk($sformatf("stall%0d wb_data", k), wb_data, 32'h100);
            chk($sformatf("stall%0d outstanding", k), 32'(outstanding), 32'd3);
        end
        wb_ack = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d wb_id", k), 32'(wb_id), 32'(k));
            chk($sformatf("drain%0d wb_data", k), wb_data, 32'h100 + 32'(k));
            chk($sformatf("drain%0d outstanding", k), 32'(outstanding), 32'(3 - k));
            rsp_data = 32'h100 + 32'(k + 1);
        end
        rsp_valid = 1'b0;
        @(negedge clk);
        wb_ack = 1'b0;
        chk("drained wb_valid", 32'(wb_valid), 32'd0);
        chk("no spurious protocol_err", 32'(protocol_err), 32'd0);

        // Flush with ids 5,6 in flight, then id 7 issued afterwards.
        req_valid = 1'b1; req_id = 3'd5; req_fn3 = FN3_LW; req_offset = 2'd0;
        @(negedge clk);
        req_id = 3'd6;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b1; req_id = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        chk("flush outstanding", 32'(outstanding), 32'd3);
        rsp_valid = 1'b1; wb_ack = 1'b1; rsp_data = 32'h55;
        @(negedge clk);
        chk("flush id5", 32'(wb_id), 32'd5);
        chk("flush id5 discard", 32'(wb_discard), 32'd1);
        rsp_data = 32'h66;
        @(negedge clk);
        chk("flush id6", 32'(wb_id), 32'd6);
        chk("flush id6 discard", 32'(wb_discard), 32'd1);
        rsp_data = 32'h77;
        @(negedge clk);
        chk("flush id7", 32'(wb_id), 32'd7);
        chk("flush id7 discard", 32'(wb_discard), 32'd0);
        chk("flush id7 data", wb_data, 32'h77);
        rsp_valid = 1'b0;
        @(negedge clk);
        wb_ack = 1'b0;
        chk("flush drained", 32'(wb_valid), 32'd0);

        // Flush while a result sits unacknowledged in the output register.
        req_valid = 1'b1; req_id = 3'd2; req_fn3 = FN3_LBU; req_offset = 2'd1;
        @(negedge clk);
        req_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_A500;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("held discard before flush", 32'(wb_discard), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("held discard after flush", 32'(wb_discard), 32'd1);
        chk("held wb_id", 32'(wb_id), 32'd2);
        chk("held wb_data", wb_data, 32'h0000_00A5);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        chk("held drained", 32'(wb_valid), 32'd0);

        // Response with nothing outstanding.
        rsp_valid = 1'b1; rsp_data = 32'hDEAD;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("perr set", 32'(protocol_err), 32'd1);
        chk("perr wb_valid", 32'(wb_valid), 32'd0);
        chk("perr outstanding", 32'(outstanding), 32'd0);
        repeat (3) @(negedge clk);
        chk("perr sticky", 32'(protocol_err), 32'd1);

        // Simultaneous push and pop keeps the count.
        req_valid = 1'b1; req_id = 3'd1; req_fn3 = FN3_LW; req_offset = 2'd0;
        @(negedge clk);
        chk("pre simul outstanding", 32'(outstanding), 32'd1);
        req_id = 3'd2; rsp_valid = 1'b1; rsp_data = 32'h1234;
        @(negedge clk);
        req_valid = 1'b0; rsp_valid = 1'b0;
        chk("simul outstanding", 32'(outstanding), 32'd1);
        chk("simul wb_id", 32'(wb_id), 32'd1);
        chk("simul wb_valid", 32'(wb_valid), 32'd1);

        // Asynchronous reset mid-operation.
        #2 rst_n = 1'b0;
        #1;
        chk("async rst outstanding", 32'(outstanding), 32'd0);
        chk("async rst protocol_err", 32'(protocol_err), 32'd0);
        chk("async rst wb_valid", 32'(wb_valid), 32'd0);
        chk("async rst req_ready", 32'(req_ready), 32'd1);
        chk("async rst rsp_ready", 32'(rsp_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst outstanding", 32'(outstanding), 32'd0);
        chk("post rst wb_id", 32'(wb_id), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
